phase_picker_4x: RTL and testbench

Digital phase picker for the 4x-oversampled CDR data-recovery path. It sits directly downstream of the 4x sampler and consumes one 4-sample nibble per bit period. It detects data-edge positions, tracks the best sampling phase with a filtered up/down counter, and emits 0, 1 or 2 recovered bits per nibble so that sender/receiver frequency offset is absorbed.

---
 rtl/phase_picker_4x.sv | 175 +++++++++++++++++
 tb/tb_phase_picker_4x.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_picker_4x.sv
// phase_picker_4x: digital phase picker for the 4x-oversampled CDR path.
// Consumes one 4-sample nibble per bit period, locates data edges, steers
// the sampling phase through a filtered up/down counter and emits 0, 1 or 2
// recovered bits per nibble to absorb sender/receiver frequency offset.
// Optional feature: define PHASE_PICKER_4X_LOCK_EN to add the lock counter
// and the out_locked port.
module phase_picker_4x #(
    parameter int PHASE_THRESH = 4,
    parameter int LOCK_NIBBLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       out_valid,
    output logic [1:0] out_count,
    output logic [1:0] out_data
`ifdef PHASE_PICKER_4X_LOCK_EN
    ,
    output logic       out_locked
`endif
);

    localparam int ACC_W = $clog2(PHASE_THRESH) + 2;
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(PHASE_THRESH);
    localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;
    localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

    logic [1:0]              sel_q, sel_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_upd;
    logic                    skip_q, skip_d;
    logic                    first_q, first_d;
    logic                    prev_q, prev_d;
    logic                    out_valid_q;
    logic [1:0]              out_count_q, out_count_d;
    logic [1:0]              out_data_q, out_data_d;

    logic [3:0] edge_v;
    logic [2:0] edge_cnt;
    logic [1:0] edge_pos;
    logic [1:0] exp_pos;
    logic [1:0] edge_dist;
    logic       late_step;
    logic       early_step;

    // Edge vector, edge count and position of a lone edge relative to the expected one
    always_comb begin
        edge_v[0]   = first_q ? 1'b0 : (in_data[0] ^ prev_q);
        edge_v[3:1] = in_data[3:1] ^ in_data[2:0];
        edge_cnt    = 3'(edge_v[0]) + 3'(edge_v[1]) + 3'(edge_v[2]) + 3'(edge_v[3]);
        edge_pos    = 2'd0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (edge_v[k]) begin
                edge_pos = 2'(k);
            end
        end
        exp_pos   = sel_q + 2'd2;
        edge_dist = edge_pos - exp_pos;
    end

    // Loop filter: single late/early edges nudge acc; reaching the threshold requests a step
    always_comb begin
        acc_upd = acc_q;
        if (edge_cnt == 3'd1) begin
            if (edge_dist == 2'd1) begin
                acc_upd = acc_q + ACC_ONE;
            end else if (edge_dist == 2'd3) begin
                acc_upd = acc_q - ACC_ONE;
            end
        end
        late_step  = (acc_upd == ACC_MAX);
        early_step = (acc_upd == ACC_MIN);
    end

    // Next-state and bit-output selection for each accepted nibble
    always_comb begin
        sel_d       = sel_q;
        acc_d       = acc_q;
        skip_d      = skip_q;
        first_d     = first_q;
        prev_d      = prev_q;
        out_count_d = out_count_q;
        out_data_d  = out_data_q;
        if (in_valid) begin
            first_d = 1'b0;
            prev_d  = in_data[3];
            acc_d   = (late_step || early_step) ? '0 : acc_upd;
            if (late_step) begin
                sel_d = sel_q + 2'd1;
            end else if (early_step) begin
                sel_d = sel_q - 2'd1;
            end
            skip_d = 1'b0;
            // The skip nibble still runs the filter; a fresh 3->0 wrap re-arms skip
            if (skip_q) begin
                out_count_d = 2'd0;
                out_data_d  = '0;
                skip_d      = late_step && (sel_q == 2'd3);
            end else if (early_step && (sel_q == 2'd0)) begin
                out_count_d = 2'd2;
                out_data_d  = {in_data[3], in_data[0]};
            end else if (late_step && (sel_q == 2'd3)) begin
                out_count_d = 2'd1;
                out_data_d  = {1'b0, in_data[3]};
                skip_d      = 1'b1;
            end else begin
                out_count_d = 2'd1;
                out_data_d  = {1'b0, in_data[sel_q]};
            end
        end
    end

    // Core state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q       <= 2'd2;
            acc_q       <= '0;
            skip_q      <= 1'b0;
            first_q     <= 1'b1;
            prev_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_data_q  <= '0;
        end else begin
            sel_q       <= sel_d;
            acc_q       <= acc_d;
            skip_q      <= skip_d;
            first_q     <= first_d;
            prev_q      <= prev_d;
            out_valid_q <= in_valid;
            out_count_q <= out_count_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_data  = out_data_q;

`ifdef PHASE_PICKER_4X_LOCK_EN
    localparam int LOCK_W = $clog2(LOCK_NIBBLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_NIBBLES);

    logic [LOCK_W-1:0] lock_q, lock_d;
    logic              locked_q, locked_d;

    // Lock counter: clean nibbles count up to saturation, steps or multi-edge nibbles clear it
    always_comb begin
        lock_d   = lock_q;
        locked_d = locked_q;
        if (in_valid) begin
            if (late_step || early_step || (edge_cnt > 3'd1)) begin
                lock_d = '0;
            end else if (lock_q != LOCK_MAX) begin
                lock_d = lock_q + LOCK_W'(1);
            end
            locked_d = (lock_d == LOCK_MAX);
        end
    end

    // Lock state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            lock_q   <= lock_d;
            locked_q <= locked_d;
        end
    end

    assign out_locked = locked_q;
`endif

endmodule

// File: tb/tb_phase_picker_4x.sv
// Self-checking bench for phase_picker_4x: directed sequences plus random
// nibbles, compared against a behavioural model of the phase-picking rules.
module tb_phase_picker_4x;

    localparam int TH = 4;
    localparam int LN = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_valid;
    logic [1:0] out_count;
    logic [1:0] out_data;
`ifdef PHASE_PICKER_4X_LOCK_EN
    logic       out_locked;
`endif

    always #5 clk = ~clk;

    phase_picker_4x #(
        .PHASE_THRESH(TH),
        .LOCK_NIBBLES(LN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_count (out_count),
        .out_data  (out_data)
`ifdef PHASE_PICKER_4X_LOCK_EN
        ,
        .out_locked(out_locked)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    int m_sel, m_acc, m_lock;
    bit m_skip, m_first, m_prev;
    int e_cnt;
    bit e_d0, e_d1, e_lock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sel = 2; m_acc = 0; m_skip = 0; m_first = 1; m_prev = 0; m_lock = 0;
        e_cnt = 0; e_d0 = 0; e_d1 = 0; e_lock = 0;
    endtask

    task automatic model_step(input logic [3:0] nib);
        int ne, pos, e, d, step;
        bit pb, lw, ew;
        ne = 0; pos = 0; step = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) pb = m_prev;
            else        pb = nib[k-1];
            if (!(k == 0 && m_first) && (nib[k] != pb)) begin
                ne++;
                pos = k;
            end
        end
        e = (m_sel + 2) % 4;
        if (ne == 1) begin
            d = (pos - e + 4) % 4;
            if (d == 1)      m_acc++;
            else if (d == 3) m_acc--;
        end
        if (m_acc == TH)  begin step = 1;  m_acc = 0; end
        if (m_acc == -TH) begin step = -1; m_acc = 0; end
        lw = (step == 1)  && (m_sel == 3);
        ew = (step == -1) && (m_sel == 0);
        if (m_skip) begin
            e_cnt = 0; m_skip = lw;
        end else if (ew) begin
            e_cnt = 2; e_d0 = nib[0]; e_d1 = nib[3];
        end else if (lw) begin
            e_cnt = 1; e_d0 = nib[3]; m_skip = 1;
        end else begin
            e_cnt = 1; e_d0 = nib[m_sel];
        end
        if (step != 0 || ne > 1) m_lock = 0;
        else if (m_lock < LN)    m_lock++;
        e_lock = (m_lock == LN);
        m_sel = (m_sel + step + 4) % 4;
        m_prev = nib[3];
        m_first = 0;
    endtask

    task automatic check_outputs(input string tag, input bit strobe);
        chk({tag, ":valid"}, 32'(out_valid), 32'(strobe));
        chk({tag, ":count"}, 32'(out_count), 32'(e_cnt));
        if (e_cnt >= 1) chk({tag, ":bit0"}, 32'(out_data[0]), 32'(e_d0));
        if (e_cnt == 2) chk({tag, ":bit1"}, 32'(out_data[1]), 32'(e_d1));
`ifdef PHASE_PICKER_4X_LOCK_EN
        chk({tag, ":locked"}, 32'(out_locked), 32'(e_lock));
`endif
    endtask

    // called at a falling edge; leaves in_valid high for back-to-back use
    task automatic send(input logic [3:0] nib, input string tag);
        in_valid = 1'b1;
        in_data  = nib;
        model_step(nib);
        @(negedge clk);
        check_outputs(tag, 1'b1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        repeat (n) begin
            @(negedge clk);
            check_outputs("idle", 1'b0);
        end
    endtask

    // nibble whose only edge sits at position k (relative to the last sample)
    function automatic logic [3:0] edge_at(input int k);
        logic [3:0] r;
        for (int j = 0; j < 4; j++) r[j] = (j < k) ? m_prev : ~m_prev;
        return r;
    endfunction

    // d: 0 aligned, 1 late, 3 early, relative to the model's current phase
    function automatic logic [3:0] rel_edge(input int d);
        return edge_at((m_sel + 2 + d) % 4);
    endfunction

    initial begin
        logic [3:0] nib;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'h0;
        model_reset();
        #2;
        chk("reset:valid", 32'(out_valid), 32'd0);
        chk("reset:count", 32'(out_count), 32'd0);
        chk("reset:data",  32'(out_data),  32'd0);
`ifdef PHASE_PICKER_4X_LOCK_EN
        chk("reset:locked", 32'(out_locked), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // constant ones, one nibble every fourth cycle
        for (int i = 0; i < 8; i++) begin
            send(4'b1111, "ones");
            idle(3);
        end

        // alternating nibbles, edge at the expected position
        for (int i = 0; i < 20; i++) begin
            send((i % 2 == 0) ? 4'b0000 : 4'b1111, "alt");
            idle(3);
        end

        // late edges: 2->3, then 3->0 wrap followed by a skipped nibble
        for (int i = 0; i < 8; i++) begin
            send(rel_edge(1), "late");
            idle(1);
        end
        send({4{m_prev}}, "skip");
        idle(2);

        // early edges from phase 0: wrap 0->3 emits two bits
        for (int i = 0; i < 4; i++) begin
            send(rel_edge(3), "early");
            idle(1);
        end

        // aligned back-to-back to reach lock, then a multi-edge nibble
        for (int i = 0; i < 17; i++) send(rel_edge(0), "aligned");
        nib = {~m_prev, m_prev, ~m_prev, m_prev};
        send(nib, "multi");
        send(rel_edge(0), "aligned2");
        send(rel_edge(0), "aligned3");
        idle(3);

        // random nibbles and random single-edge nibbles with random gaps
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0) nib = 4'($urandom);
            else                          nib = edge_at(int'($urandom_range(0, 3)));
            send(nib, "rand");
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        // fresh reset, then bring the phase to 3 with acc at +2
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        send(4'b0000, "pre");
        for (int i = 0; i < 6; i++) send(rel_edge(1), "pre_late");

        // asynchronous reset mid-stream while out_valid is high
        in_valid = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        #1;
        chk("midrst:valid", 32'(out_valid), 32'd0);
        chk("midrst:count", 32'(out_count), 32'd0);
        chk("midrst:data",  32'(out_data),  32'd0);
`ifdef PHASE_PICKER_4X_LOCK_EN
        chk("midrst:locked", 32'(out_locked), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // first nibble: bit0 differs from the cleared prev, which must not count
        send(4'b0001, "post_first");
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) nib = 4'($urandom);
            else                          nib = rel_edge(1);
            send(nib, "post");
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
